river_rider: RTL and testbench
==============================

# river_rider

Consumes the per-frame position and collision outputs of the lilypad row and decides what happens to the frog while it is in the river band. Each frame it either carries the frog with the pad it stands on or declares a drowning. It emits a signed per-frame X drift that the frog controller adds to Frog_X, plus a sticky drown flag for the game-state logic. It sits between the lilypad instances and the frog controller.

## Interface
- NUM_PADS, 4: lilypads in the river.
- RIVER_Y_TOP, 80: first frog Y (inclusive) inside the river band.
- RIVER_Y_BOT, 200: last frog Y (inclusive) inside the river band.
- PAD_STEP, 20: legal magnitude of one pad move.
- GRACE_FRAMES, 2: frames the frog may be in the river with no pad contact before drowning.
- FROG_SIDE, 40: frog width. The legal frog X range is 0..640-FROG_SIDE.

Ports:
- frame_clk  in  1: sole clock, one edge per video frame.
- Reset  in  1: synchronous, active-high.
- Frog_X, Frog_Y  in  11 each: current frog position.
- LPad_X  in  11*NUM_PADS: pad i occupies bits [11i+10:11i].
- LPad_Collision  in  NUM_PADS: bit i high when the frog overlaps pad i.
- win, lose  in  1 each: game-over freeze.
- Drift_X  out  11: two's-complement X delta to apply this frame.
- Drift_Valid  out  1: one-frame pulse, high when Drift_X is nonzero.
- Drown  out  1: sticky drowning flag.
- Ride_Pad  out  3: index of the pad being ridden. Valid only in RIDE.
- Rider_State  out  2: LAND=0, RIDE=1, GRACE=2, DROWNED=3.

## Operation
- in_river = (RIVER_Y_TOP <= Frog_Y <= RIVER_Y_BOT).
- Per pad:
  - Register prev_x[i] every frame.
  - delta[i] = LPad_X[i] - prev_x[i] (11-bit wrap arithmetic).
  - A move is legal when delta is 0, +PAD_STEP, or -PAD_STEP. Any other value is a screen wrap.
- Selected pad = lowest index i with LPad_Collision[i] = 1. Ride_Pad = that index.
- States:
  - LAND:
    - !in_river: stay; Drift = 0.
    - in_river with any collision: go to RIDE.
    - in_river with no collision: go to GRACE, grace counter = 1.
  - RIDE:
    - !in_river: go to LAND.
    - No collision: go to GRACE, counter = 1.
    - Selected pad delta is a wrap: go to DROWNED.
    - Frog_X + delta outside 0..640-FROG_SIDE (signed compare): go to DROWNED, Drift = 0.
    - Otherwise Drift_X = delta. Drift_Valid = 1 if delta is nonzero.
  - GRACE:
    - Collision: go to RIDE. Drift is applied starting the next frame.
    - !in_river: go to LAND.
    - Counter == GRACE_FRAMES: go to DROWNED.
    - Otherwise counter += 1.
  - DROWNED:
    - Drown = 1 and Drift = 0.
    - Leaves only when !in_river (frog respawned); goes to LAND with Drown cleared on the same edge.
- Freeze: while win or lose is high, state, counter and outputs hold, and Drift_Valid = 0. prev_x still updates.
- Reset values: state = LAND, counter = 0, prev_x[i] = current LPad_X[i], Drift_X = 0, Drift_Valid = 0, Drown = 0, Ride_Pad = 0.

## Timing
- All outputs are registered.
- A pad move on edge k is visible as Drift_X on edge k+1, so the frog lags the pad by exactly one frame.
- Drift_Valid is never high on two consecutive frames unless the pad moves on consecutive frames.
- Reset asserted mid-RIDE: outputs go to reset values on that edge, and the first delta after release is 0.
- Collision loss and a pad move in the same frame: GRACE wins, no drift.
- Frog exits the band on the same frame a drown would trigger: the LAND transition wins.

## Test plan
- Frog_Y = 120 on pad 0; pad 0 moves 100 -> 120 -> Drift_X = 20 and Drift_Valid = 1 one frame later, state RIDE, Ride_Pad = 0.
- Left-moving pad 100 -> 80 -> Drift_X = 11'h7EC (-20). Pads 1 and 2 both colliding -> Ride_Pad = 1.
- Frog in band with no collision for 3 frames and GRACE_FRAMES = 2 -> states GRACE, GRACE, DROWNED, then Drown = 1 held; Frog_Y = 440 -> LAND and Drown = 0.
- Riding pad wraps 0 -> 640, or Frog_X = 600 with delta +20 -> DROWNED, Drift_X = 0.
- lose = 1 while riding and pad moving -> Drift_Valid stays 0 and state holds; lose = 0 -> riding resumes with the next legal delta.
- Reset pulse during RIDE -> next edge: state LAND, all outputs 0, no spurious drift on the first frame after release.

Source files
------------

// File: rtl/river_rider.sv
// River-band rider: carries the frog with the lilypad it stands on, or drowns it when it has
// no pad contact, the pad wraps around the screen, or the carry would push it off screen.
module river_rider #(
   parameter int unsigned NUM_PADS     = 4,
   parameter int unsigned RIVER_Y_TOP  = 80,
   parameter int unsigned RIVER_Y_BOT  = 200,
   parameter int unsigned PAD_STEP     = 20,
   parameter int unsigned GRACE_FRAMES = 2,
   parameter int unsigned FROG_SIDE    = 40
) (
   input  logic                    frame_clk,
   input  logic                    Reset,
   input  logic [10:0]             Frog_X,
   input  logic [10:0]             Frog_Y,
   input  logic [11*NUM_PADS-1:0]  LPad_X,
   input  logic [NUM_PADS-1:0]     LPad_Collision,
   input  logic                    win,
   input  logic                    lose,
   output logic [10:0]             Drift_X,
   output logic                    Drift_Valid,
   output logic                    Drown,
   output logic [2:0]              Ride_Pad,
   output logic [1:0]              Rider_State
);

   localparam int unsigned CW   = $clog2(GRACE_FRAMES + 1);
   localparam int unsigned XMAX = 640 - FROG_SIDE;

   typedef enum logic [1:0] {
      StLand    = 2'd0,
      StRide    = 2'd1,
      StGrace   = 2'd2,
      StDrowned = 2'd3
   } state_e;

   state_e                  r_state;
   state_e                  w_state_d;
   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           w_cnt_d;
   logic [11*NUM_PADS-1:0]  r_prev_x;
   logic [10:0]             r_drift_x;
   logic                    r_drift_valid;
   logic                    r_drown;
   logic [2:0]              r_ride_pad;

   logic                    w_in_river;
   logic                    w_any;
   logic                    w_freeze;
   logic [2:0]              w_sel;
   logic [10:0]             w_sel_delta;
   logic                    w_legal;
   logic [12:0]             w_sum;
   logic                    w_out;
   logic [10:0]             w_drift_d;

   assign w_in_river = (Frog_Y >= 11'(RIVER_Y_TOP)) && (Frog_Y <= 11'(RIVER_Y_BOT));
   assign w_any      = |LPad_Collision;
   assign w_freeze   = win | lose;

   // Lowest-index colliding pad wins; scan from the top so lower indices overwrite.
   always_comb begin
      w_sel       = 3'd0;
      w_sel_delta = 11'd0;
      for (int i = NUM_PADS - 1; i >= 0; i--) begin
         if (LPad_Collision[i]) begin
            w_sel       = 3'(i);
            w_sel_delta = LPad_X[11*i +: 11] - r_prev_x[11*i +: 11];
         end
      end
   end

   assign w_legal = (w_sel_delta == 11'd0) || (w_sel_delta == 11'(PAD_STEP)) ||
                    (w_sel_delta == (11'd0 - 11'(PAD_STEP)));

   // 13-bit sum so a negative result or one beyond the right edge is visible.
   assign w_sum = {2'b00, Frog_X} + {{2{w_sel_delta[10]}}, w_sel_delta};
   assign w_out = w_sum[12] || (w_sum[11:0] > 12'(XMAX));

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_drift_d = 11'd0;
      case (r_state)
         StLand: begin
            if (w_in_river) begin
               if (w_any) begin
                  w_state_d = StRide;
               end else begin
                  w_state_d = StGrace;
                  w_cnt_d   = CW'(1);
               end
            end
         end
         StRide: begin
            if (!w_in_river) begin
               w_state_d = StLand;
            end else if (!w_any) begin
               w_state_d = StGrace;
               w_cnt_d   = CW'(1);
            end else if (!w_legal || w_out) begin
               w_state_d = StDrowned;
            end else begin
               w_drift_d = w_sel_delta;
            end
         end
         StGrace: begin
            if (w_any) begin
               w_state_d = StRide;
            end else if (!w_in_river) begin
               w_state_d = StLand;
            end else if (r_cnt == CW'(GRACE_FRAMES)) begin
               w_state_d = StDrowned;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         StDrowned: begin
            if (!w_in_river) begin
               w_state_d = StLand;
            end
         end
      endcase
   end

   // prev_x tracks the pads even during reset and freeze so deltas never span a gap.
   always_ff @(posedge frame_clk) begin
      r_prev_x <= LPad_X;
      if (Reset) begin
         r_state       <= StLand;
         r_cnt         <= '0;
         r_drift_x     <= 11'd0;
         r_drift_valid <= 1'b0;
         r_drown       <= 1'b0;
         r_ride_pad    <= 3'd0;
      end else if (w_freeze) begin
         r_drift_valid <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_cnt         <= w_cnt_d;
         r_drift_x     <= w_drift_d;
         r_drift_valid <= |w_drift_d;
         r_drown       <= (w_state_d == StDrowned);
         r_ride_pad    <= (w_state_d == StRide) ? w_sel : 3'd0;
      end
   end

   assign Drift_X     = r_drift_x;
   assign Drift_Valid = r_drift_valid;
   assign Drown       = r_drown;
   assign Ride_Pad    = r_ride_pad;
   assign Rider_State = r_state;

endmodule

// File: tb/tb_river_rider.sv
// Directed bench for river_rider: stimulus queues the expected registered outputs for each
// frame edge and a separate monitor pops and compares them on the falling edge.
module tb_river_rider;

   localparam logic [1:0] LAND = 2'd0;
   localparam logic [1:0] RIDE = 2'd1;
   localparam logic [1:0] GRC  = 2'd2;
   localparam logic [1:0] DRN  = 2'd3;

   logic        frame_clk = 1'b0;
   logic        rst;
   logic [10:0] fx, fy;
   logic [10:0] px [4];
   logic [43:0] lpad_x;
   logic [3:0]  coll;
   logic        win, lose;
   logic [10:0] drift_x;
   logic        drift_valid, drown;
   logic [2:0]  ride_pad;
   logic [1:0]  rider_state;

   typedef struct {
      string       nm;
      logic [17:0] exp;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 frame_clk = ~frame_clk;

   assign lpad_x = {px[3], px[2], px[1], px[0]};

   river_rider dut (
      .frame_clk      (frame_clk),
      .Reset          (rst),
      .Frog_X         (fx),
      .Frog_Y         (fy),
      .LPad_X         (lpad_x),
      .LPad_Collision (coll),
      .win            (win),
      .lose           (lose),
      .Drift_X        (drift_x),
      .Drift_Valid    (drift_valid),
      .Drown          (drown),
      .Ride_Pad       (ride_pad),
      .Rider_State    (rider_state)
   );

   // Expected outputs after the next rising edge: {state, drift, valid, drown, pad}.
   task automatic step(input string nm, input logic [1:0] st, input logic [10:0] dx,
                       input logic dv, input logic dn, input logic [2:0] rp);
      exp_t e;
      @(posedge frame_clk);
      e.nm  = nm;
      e.exp = {st, dx, dv, dn, rp};
      q.push_back(e);
      @(negedge frame_clk);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [17:0] act;
      forever begin
         @(negedge frame_clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {rider_state, drift_x, drift_valid, drown, ride_pad};
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s: got st=%0d dx=%h dv=%b dn=%b rp=%0d, want st=%0d dx=%h dv=%b dn=%b rp=%0d",
                        e.nm, act[17:16], act[15:5], act[4], act[3], act[2:0],
                        e.exp[17:16], e.exp[15:5], e.exp[4], e.exp[3], e.exp[2:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1);
   end

   initial begin : stim
      rst = 1'b1; fx = 11'd100; fy = 11'd440; coll = 4'b0000; win = 1'b0; lose = 1'b0;
      px[0] = 11'd100; px[1] = 11'd300; px[2] = 11'd400; px[3] = 11'd500;
      @(negedge frame_clk);
      step("reset", LAND, 11'd0, 1'b0, 1'b0, 3'd0);
      rst = 1'b0;
      step("land_idle", LAND, 11'd0, 1'b0, 1'b0, 3'd0);
      fy = 11'd120; coll = 4'b0001;
      step("enter_ride", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      px[0] = 11'd120;
      step("ride_right", RIDE, 11'd20, 1'b1, 1'b0, 3'd0);
      fx = 11'd120;
      step("ride_still", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      px[0] = 11'd100;
      step("ride_left", RIDE, 11'h7EC, 1'b1, 1'b0, 3'd0);
      fx = 11'd100; coll = 4'b0110;
      step("two_pads", RIDE, 11'd0, 1'b0, 1'b0, 3'd1);
      px[1] = 11'd320;
      step("pad1_move", RIDE, 11'd20, 1'b1, 1'b0, 3'd1);
      coll = 4'b0000; px[1] = 11'd340;
      step("loss_grace", GRC, 11'd0, 1'b0, 1'b0, 3'd0);
      step("grace2", GRC, 11'd0, 1'b0, 1'b0, 3'd0);
      step("drowned", DRN, 11'd0, 1'b0, 1'b1, 3'd0);
      step("drown_hold", DRN, 11'd0, 1'b0, 1'b1, 3'd0);
      fy = 11'd440;
      step("respawn", LAND, 11'd0, 1'b0, 1'b0, 3'd0);
      fy = 11'd120;
      step("grace_a", GRC, 11'd0, 1'b0, 1'b0, 3'd0);
      coll = 4'b0001; px[0] = 11'd120;
      step("grace_to_ride", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      px[0] = 11'd140;
      step("after_grace", RIDE, 11'd20, 1'b1, 1'b0, 3'd0);
      fx = 11'd120; px[0] = 11'd640;
      step("wrap", DRN, 11'd0, 1'b0, 1'b1, 3'd0);
      fy = 11'd440;
      step("exit_wrap", LAND, 11'd0, 1'b0, 1'b0, 3'd0);
      fy = 11'd120; fx = 11'd600;
      step("enter_edge", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      px[0] = 11'd660;
      step("x_over", DRN, 11'd0, 1'b0, 1'b1, 3'd0);
      fy = 11'd440;
      step("exit2", LAND, 11'd0, 1'b0, 1'b0, 3'd0);
      fy = 11'd120; coll = 4'b0000;
      step("grace_b1", GRC, 11'd0, 1'b0, 1'b0, 3'd0);
      step("grace_b2", GRC, 11'd0, 1'b0, 1'b0, 3'd0);
      fy = 11'd440;
      step("exit_beats_drown", LAND, 11'd0, 1'b0, 1'b0, 3'd0);
      fy = 11'd120; coll = 4'b0001; fx = 11'd100;
      step("ride_again", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      px[0] = 11'd680;
      step("pre_freeze", RIDE, 11'd20, 1'b1, 1'b0, 3'd0);
      lose = 1'b1; px[0] = 11'd700;
      step("freeze1", RIDE, 11'd20, 1'b0, 1'b0, 3'd0);
      px[0] = 11'd720;
      step("freeze2", RIDE, 11'd20, 1'b0, 1'b0, 3'd0);
      lose = 1'b0;
      step("unfreeze_still", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      px[0] = 11'd740;
      step("resume", RIDE, 11'd20, 1'b1, 1'b0, 3'd0);
      rst = 1'b1; px[0] = 11'd760;
      step("reset_mid", LAND, 11'd0, 1'b0, 1'b0, 3'd0);
      rst = 1'b0;
      step("post_reset", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      step("post_reset_still", RIDE, 11'd0, 1'b0, 1'b0, 3'd0);
      fx = 11'd10; px[0] = 11'd740;
      step("x_under", DRN, 11'd0, 1'b0, 1'b1, 3'd0);
      @(negedge frame_clk);
      @(negedge frame_clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
